// File: rtl/scoreboard_pkg.sv
// Shared constants and types for the register-hazard scoreboard.
// Pipeline latency classes are the issue-to-writeback distances of the 5-stage core.
package scoreboard_pkg;

    localparam int REG_AW      = 5;
    localparam int MAX_LAT_DEF = 7;
    localparam int LAT_W_DEF   = $clog2(MAX_LAT_DEF + 1);

    typedef logic [LAT_W_DEF-1:0] lat_t;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_LOAD_IMM
    } instr_class_t;

    localparam lat_t LAT_ALU      = lat_t'(3);
    localparam lat_t LAT_LOAD     = lat_t'(4);
    localparam lat_t LAT_LOAD_IMM = lat_t'(2);

    // Latency the issue logic should present for a given instruction class.
    function automatic lat_t class_lat(input instr_class_t cls);
        lat_t lat;
        lat = LAT_ALU;
        case (cls)
            CLS_LOAD:     lat = LAT_LOAD;
            CLS_LOAD_IMM: lat = LAT_LOAD_IMM;
            default:      lat = LAT_ALU;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// One per-register countdown: counts the cycles until a pending write lands.
// A load takes priority over the decrement in the same cycle.
module sb_counter #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] cnt,
    output logic             nonzero
);

    // NOTE: the counters are individual flops, not a RAM, so every one is reset; sequential state uses <= only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    assign nonzero = (cnt != '0);

endmodule

// File: rtl/reg_scoreboard_param.sv
// Register-hazard scoreboard: per-register countdown counters drive a combinational
// RAW/WAW stall so mixed-latency units can issue in order.
module reg_scoreboard_param #(
    parameter int NUM_REGS      = 32,
    parameter int REG_AW        = scoreboard_pkg::REG_AW,
    parameter int MAX_LAT       = scoreboard_pkg::MAX_LAT_DEF,
    parameter int LAT_W         = scoreboard_pkg::LAT_W_DEF,
    parameter int WRITE_THROUGH = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [REG_AW-1:0]   src0,
    input  logic                src0_used,
    input  logic [REG_AW-1:0]   src1,
    input  logic                src1_used,
    input  logic [REG_AW-1:0]   dst,
    input  logic                dst_used,
    input  logic [LAT_W-1:0]    issue_lat,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy,
    output logic [31:0]         stall_cycles
);

    import scoreboard_pkg::*;

    localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] nz;
    logic [LAT_W-1:0]    lat_eff;
    logic                raw0, raw1, waw;
    logic                accept;
    logic                load_en;
    logic [31:0]         stall_cnt_q;

    // With a write-through register file the final countdown cycle is already readable.
    function automatic logic raw_hit(input logic [LAT_W-1:0] c);
        return (WRITE_THROUGH != 0) ? (c > LAT_W'(1)) : (c != '0);
    endfunction

    assign lat_eff = (issue_lat > MAX_LAT_V) ? MAX_LAT_V : issue_lat;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        raw0  = 1'b0;
        raw1  = 1'b0;
        waw   = 1'b0;
        stall = 1'b0;
        if (src0_used && (src0 != '0)) raw0 = raw_hit(cnt[src0]);
        if (src1_used && (src1 != '0)) raw1 = raw_hit(cnt[src1]);
        if (dst_used && (dst != '0))   waw  = (cnt[dst] > lat_eff);
        stall = issue_valid && (raw0 || raw1 || waw);
    end

    // Stall reaches the counters only through this gate; a zero latency never marks.
    assign accept  = issue_valid && !stall;
    assign load_en = accept && dst_used && (lat_eff != '0);

    assign cnt[0] = '0;
    assign nz[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_counter #(
            .LAT_W(LAT_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .load    (load_en && (dst == REG_AW'(r))),
            .load_val(lat_eff),
            .cnt     (cnt[r]),
            .nonzero (nz[r])
        );
    end

    assign busy = nz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule
